rolha_dispenser_ctrl: RTL and testbench

Parametrised stopper (rolha) dispenser controller for the capping station of the bottling line. It tracks the stopper reservoir with a saturating stock counter and accepts operator refills in batches. It serves one bottle per request through a timed actuator pulse with a completion acknowledge, and flags low, empty, full and starved conditions to the line supervisor.

---
 rtl/rolha_dispenser_ctrl.sv | 152 +++++++++++++++
 tb/tb_rolha_dispenser_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rolha_dispenser_ctrl.sv
// ============================================================================
// Module   : rolha_dispenser_ctrl
// Brief    : Stopper dispenser controller: stock counter, batch refills,
//            timed dispense pulse with ack. Optional DISPENSER_TALLY_EN
//            adds a 16-bit completed-dispense tally port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rolha_dispenser_ctrl #(
    parameter int CAPACITY    = 20,
    parameter int CNT_W       = 5,
    parameter int ADD_BATCH   = 5,
    parameter int LOW_LEVEL   = 5,
    parameter int DISP_CYCLES = 3,
    parameter int INIT_STOCK  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             switch_add_rolha,
    output logic             disp,
    output logic             ack,
    output logic             add_rolha,
    output logic [CNT_W-1:0] stock,
    output logic             low,
    output logic             empty,
    output logic             full,
`ifdef DISPENSER_TALLY_EN
    output logic [15:0]      total,
`endif
    output logic             fault
);

    localparam int TW = $clog2(DISP_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DISP     = 3'd1;
    localparam logic [2:0] S_DONE     = 3'd2;
    localparam logic [2:0] S_WAIT_REL = 3'd3;
    localparam logic [2:0] S_STARVED  = 3'd4;

    localparam logic [TW-1:0]    TIMER_LOAD = TW'(DISP_CYCLES - 1);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [CNT_W:0]   CAP_X      = (CNT_W + 1)'(CAPACITY);
    localparam logic [CNT_W:0]   BATCH_X    = (CNT_W + 1)'(ADD_BATCH);
    localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] LOW_C      = CNT_W'(LOW_LEVEL);
    localparam logic [CNT_W-1:0] INIT_C     = CNT_W'(INIT_STOCK);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_next;
    logic             sw_q;
    logic             refill_edge;
    logic             dec_now;
    logic [CNT_W:0]   base;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] stock_next;
    logic             add_next;

    // Refill is judged against the post-decrement level, so a refill that
    // coincides with a completing dispense is never blocked by "full".
    always_comb begin
        refill_edge = switch_add_rolha & ~sw_q;
        dec_now     = (state == S_DISP) && (timer == '0);
        base        = {1'b0, stock} - {{CNT_W{1'b0}}, dec_now};
        sum         = base + BATCH_X;
        stock_next  = base[CNT_W-1:0];
        add_next    = 1'b0;
        if (refill_edge && (base < CAP_X)) begin
            add_next   = 1'b1;
            stock_next = (sum > CAP_X) ? CAP_C : sum[CNT_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (stock != '0) begin
                        state_next = S_DISP;
                        timer_next = TIMER_LOAD;
                    end else begin
                        state_next = S_STARVED;
                    end
                end
            end
            S_DISP: begin
                if (timer == '0) state_next = S_DONE;
                else             timer_next = timer - TIMER_ONE;
            end
            S_DONE: begin
                state_next = req ? S_WAIT_REL : S_IDLE;
            end
            S_WAIT_REL: begin
                if (!req) state_next = S_IDLE;
            end
            S_STARVED: begin
                if (!req) begin
                    state_next = S_IDLE;
                end else if (stock != '0) begin
                    state_next = S_DISP;
                    timer_next = TIMER_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            sw_q      <= 1'b0;
            stock     <= INIT_C;
            add_rolha <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            sw_q      <= switch_add_rolha;
            stock     <= stock_next;
            add_rolha <= add_next;
        end
    end

`ifdef DISPENSER_TALLY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total <= 16'd0;
        end else if (dec_now && (total != 16'hFFFF)) begin
            total <= total + 16'd1;
        end
    end
`endif

    assign disp  = (state == S_DISP);
    assign ack   = (state == S_DONE);
    assign fault = (state == S_STARVED);
    assign low   = (stock <= LOW_C);
    assign empty = (stock == '0);
    assign full  = (stock == CAP_C);

endmodule

`default_nettype wire

// File: tb/tb_rolha_dispenser_ctrl.sv
// ============================================================================
// Module   : tb_rolha_dispenser_ctrl
// Brief    : Self-checking bench: cycle model of dispenser behaviour plus
//            directed scenarios with literal expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rolha_dispenser_ctrl;

    localparam int CAPACITY    = 20;
    localparam int CNT_W       = 5;
    localparam int ADD_BATCH   = 5;
    localparam int LOW_LEVEL   = 5;
    localparam int DISP_CYCLES = 3;
    localparam int INIT_STOCK  = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic             sw = 1'b0;
    logic             disp;
    logic             ack;
    logic             add_rolha;
    logic [CNT_W-1:0] stock;
    logic             low;
    logic             empty;
    logic             full;
    logic             fault;
`ifdef DISPENSER_TALLY_EN
    logic [15:0]      total;
`endif

    int errors = 0;
    int checks = 0;

    rolha_dispenser_ctrl #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .ADD_BATCH(ADD_BATCH),
        .LOW_LEVEL(LOW_LEVEL), .DISP_CYCLES(DISP_CYCLES), .INIT_STOCK(INIT_STOCK)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .req(req),
        .switch_add_rolha(sw),
        .disp(disp),
        .ack(ack),
        .add_rolha(add_rolha),
        .stock(stock),
        .low(low),
        .empty(empty),
        .full(full),
`ifdef DISPENSER_TALLY_EN
        .total(total),
`endif
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining actuator cycles, pending ack, release wait, starvation.
    int m_stock = INIT_STOCK;
    int m_left = 0;
    int m_total = 0;
    bit m_ack = 0, m_add = 0, m_wait = 0, m_starved = 0, m_prev_sw = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int  n_stock, n_left;
        bit  n_ack, n_add, n_wait, n_starved, edg, fin;
        if (!rst_n) begin
            m_stock = INIT_STOCK; m_left = 0; m_total = 0;
            m_ack = 0; m_add = 0; m_wait = 0; m_starved = 0; m_prev_sw = 0;
        end else begin
            edg = sw && !m_prev_sw;
            m_prev_sw = sw;
            fin = (m_left == 1);
            n_stock = m_stock - (fin ? 1 : 0);
            n_add = 0;
            if (edg && n_stock < CAPACITY) begin
                n_add = 1;
                n_stock = n_stock + ADD_BATCH;
                if (n_stock > CAPACITY) n_stock = CAPACITY;
            end
            if (fin && m_total < 65535) m_total++;
            n_left = m_left; n_ack = 0; n_wait = m_wait; n_starved = m_starved;
            if (m_left > 0) begin
                n_left = m_left - 1;
                n_ack = fin;
            end else if (m_ack || m_wait) begin
                n_wait = req;
            end else if (m_starved) begin
                if (!req) n_starved = 0;
                else if (m_stock != 0) begin n_starved = 0; n_left = DISP_CYCLES; end
            end else if (req) begin
                if (m_stock != 0) n_left = DISP_CYCLES;
                else n_starved = 1;
            end
            m_stock = n_stock; m_left = n_left; m_ack = n_ack; m_add = n_add;
            m_wait = n_wait; m_starved = n_starved;
        end
    end

    always @(negedge clk) begin
        check("disp", 32'(disp), 32'(m_left > 0));
        check("ack", 32'(ack), 32'(m_ack));
        check("add_rolha", 32'(add_rolha), 32'(m_add));
        check("stock", 32'(stock), 32'(m_stock));
        check("low", 32'(low), 32'(m_stock <= LOW_LEVEL));
        check("empty", 32'(empty), 32'(m_stock == 0));
        check("full", 32'(full), 32'(m_stock == CAPACITY));
        check("fault", 32'(fault), 32'(m_starved));
`ifdef DISPENSER_TALLY_EN
        check("total", 32'(total), 32'(m_total));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        sw = 1'b1; step(1);
        sw = 1'b0; step(1);
    endtask

    task automatic dispense();
        req = 1'b1; step(1);
        req = 1'b0; step(4);
    endtask

    initial begin
        step(2);
        check("rst_stock", 32'(stock), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_low", 32'(low), 1);
        check("rst_disp", 32'(disp), 0);
        rst_n = 1'b1;
        step(1);

        // Starved start
        req = 1'b1; step(1);
        check("starved_fault", 32'(fault), 1);
        check("starved_disp", 32'(disp), 0);
        step(1);
        sw = 1'b1; step(1);
        check("starved_add", 32'(add_rolha), 1);
        check("starved_stock5", 32'(stock), 5);
        sw = 1'b0; step(1);
        check("starved_disp_on", 32'(disp), 1);
        check("starved_fault_off", 32'(fault), 0);
        step(2);
        check("disp_third", 32'(disp), 1);
        step(1);
        check("first_ack", 32'(ack), 1);
        check("first_stock4", 32'(stock), 4);

        // Held request: no second dispense until req drops
        step(3);
        check("held_no_disp", 32'(disp), 0);
        check("held_stock4", 32'(stock), 4);
        req = 1'b0; step(1);
        req = 1'b1; step(1);
        check("redisp_on", 32'(disp), 1);
        req = 1'b0; step(3);
        check("second_ack", 32'(ack), 1);
        check("second_stock3", 32'(stock), 3);
        step(1);

        // Refill saturation
        repeat (4) press();
        check("sat_stock20", 32'(stock), 20);
        check("sat_full", 32'(full), 1);
        sw = 1'b1; step(1);
        check("sat_no_add", 32'(add_rolha), 0);
        check("sat_stock_hold", 32'(stock), 20);
        sw = 1'b0; step(1);

        // Simultaneous refill and dispense completion
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; step(1);
        press();
        check("sim_stock5", 32'(stock), 5);
        req = 1'b1; step(1);
        req = 1'b0; step(2);
        sw = 1'b1; step(1);
        check("sim_ack", 32'(ack), 1);
        check("sim_add", 32'(add_rolha), 1);
        check("sim_stock9", 32'(stock), 9);
        sw = 1'b0; step(1);

        // Low flag
        repeat (3) dispense();
        check("low_stock6", 32'(stock), 6);
        check("low_off", 32'(low), 0);
        dispense();
        check("low_stock5", 32'(stock), 5);
        check("low_on", 32'(low), 1);
`ifdef DISPENSER_TALLY_EN
        check("tally5", 32'(total), 5);
`endif

        // Reset in the second actuator cycle
        req = 1'b1; step(1);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_disp", 32'(disp), 0);
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_stock", 32'(stock), 0);
        req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_disp", 32'(disp), 0);
        check("post_rst_fault", 32'(fault), 0);
        check("post_rst_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
